world_map_arbiter: RTL and testbench

Shares the single-port, synchronous-read world-map memory between the VGA pixel fetch path and the robot sensor/location reader. The VGA path has priority so the colorizer receives a pixel code every requested cycle; robot reads are served in idle slots, with a starvation override that steals one VGA slot. The block sits between the display timing logic and the colorizer on one side, and the rojobot world interface on the other.

---
 rtl/world_map_arbiter_if.sv | 27 ++
 rtl/world_map_arbiter.sv | 84 ++++++++
 tb/tb_world_map_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/world_map_arbiter_if.sv
// world_map_arbiter_if: VGA fetch, robot read and world-map memory signals around the arbiter.
// The arbiter takes the slave view; the display/robot/memory side takes the master view.
interface world_map_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 2
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] world_pixel;
    logic              vid_valid;
    logic              vid_dropped;
    logic              bot_req;
    logic [ADDR_W-1:0] bot_addr;
    logic              bot_ack;
    logic [DATA_W-1:0] bot_data;
    logic [ADDR_W-1:0] map_addr;
    logic [DATA_W-1:0] map_data;

    modport slave (
        input  vid_req, vid_addr, bot_req, bot_addr, map_data,
        output world_pixel, vid_valid, vid_dropped, bot_ack, bot_data, map_addr
    );
    modport master (
        output vid_req, vid_addr, bot_req, bot_addr, map_data,
        input  world_pixel, vid_valid, vid_dropped, bot_ack, bot_data, map_addr
    );
endinterface

// File: rtl/world_map_arbiter.sv
// world_map_arbiter: shares the world-map memory between VGA pixel fetch (priority) and robot reads.
// Define WMAP_ARB_STARVE_EN to let a starved robot read steal one VGA slot.
module world_map_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 2,
    parameter int STARVE_LIMIT = 15
) (
    input logic                clk_i,
    input logic                rst_i,
    world_map_arbiter_if.slave bus
);
    localparam logic [1:0] B_IDLE = 2'd0, B_WAIT = 2'd1, B_FLIGHT = 2'd2;
    localparam logic [1:0] T_NONE = 2'd0, T_VID = 2'd1, T_BOT = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    logic [1:0]        st_q, st_d, tag1_q, tag1_d, tag2_q;
    logic [ADDR_W-1:0] map_addr_q, map_addr_d;
    logic [DATA_W-1:0] pix_q, bdat_q;
    logic              vv_q, ack_q;
    logic              bot_pend, bot_gnt, tag2_bot, tag2_drop;

    // The cycle right after an ack ignores bot_req so a requester still holding it gets one read.
    assign bot_pend = bus.bot_req && ((st_q == B_IDLE && !ack_q) || st_q == B_WAIT);
`ifdef WMAP_ARB_STARVE_EN
    localparam logic [1:0] T_DROP = 2'd3;
    logic [7:0] cnt_q, cnt_d;
    logic       vd_q;
    assign bot_gnt   = bot_pend && (!bus.vid_req || cnt_q == 8'(STARVE_LIMIT));
    assign cnt_d     = (bot_gnt || !bot_pend) ? 8'd0 :
                       cnt_q == 8'(STARVE_LIMIT) ? cnt_q : cnt_q + 8'd1;
    assign tag1_d    = bot_gnt ? (bus.vid_req ? T_DROP : T_BOT) : bus.vid_req ? T_VID : T_NONE;
    assign tag2_drop = tag2_q == T_DROP;
    assign bus.vid_dropped = vd_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            vd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vd_q  <= tag2_drop;
        end
    end
`else
    assign bot_gnt   = bot_pend && !bus.vid_req;
    assign tag1_d    = bot_gnt ? T_BOT : bus.vid_req ? T_VID : T_NONE;
    assign tag2_drop = 1'b0;
    assign bus.vid_dropped = 1'b0;
`endif
    assign tag2_bot   = tag2_q == T_BOT || tag2_drop;
    assign st_d       = st_q == B_FLIGHT ? (tag2_bot ? B_IDLE : B_FLIGHT) :
                        bot_gnt ? B_FLIGHT : bot_pend ? B_WAIT : B_IDLE;
    assign map_addr_d = bot_gnt ? bus.bot_addr : bus.vid_req ? bus.vid_addr : map_addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q       <= B_IDLE;
            tag1_q     <= T_NONE;
            tag2_q     <= T_NONE;
            map_addr_q <= '0;
            pix_q      <= '0;
            bdat_q     <= '0;
            vv_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            map_addr_q <= map_addr_d;
            vv_q       <= tag2_q == T_VID || tag2_drop;
            ack_q      <= tag2_bot;
            if (tag2_q == T_VID) pix_q <= bus.map_data;
            if (tag2_bot) bdat_q <= bus.map_data;
        end
    end

    assign bus.world_pixel = pix_q;
    assign bus.vid_valid   = vv_q;
    assign bus.bot_ack     = ack_q;
    assign bus.bot_data    = bdat_q;
    assign bus.map_addr    = map_addr_q;
endmodule

// File: tb/tb_world_map_arbiter.sv
// tb_world_map_arbiter: directed table, corner sequences and random traffic against a
// cycle-scheduled reference model of the arbiter with a synchronous-read memory.
module tb_world_map_arbiter;
    localparam int AW = 14, DW = 2, LIM = 15;
`ifdef WMAP_ARB_STARVE_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    typedef struct {
        logic          vr;
        logic [AW-1:0] va;
        logic          br;
        logic [AW-1:0] ba;
        logic          vv;
        logic          vd;
        logic [DW-1:0] pix;
        logic          ack;
        logic [DW-1:0] bd;
        logic [AW-1:0] ma;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errs = 0, checks = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    vec_t tbl [22];

    world_map_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    world_map_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.map_data <= mem[bus.map_addr];

    // Reference model: each accepted request schedules its result two edges ahead.
    logic          s_vv [4], s_vd [4], s_ack [4];
    logic [DW-1:0] s_pix [4], s_bd [4];
    logic          e_vv, e_vd, e_ack;
    logic [DW-1:0] e_pix, e_bd;
    logic [AW-1:0] e_ma;
    int            cyc, ack_at, deny;
    bit            waiting;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            s_vv[i] = 0; s_vd[i] = 0; s_ack[i] = 0; s_pix[i] = 0; s_bd[i] = 0;
        end
        e_vv = 0; e_vd = 0; e_ack = 0; e_pix = 0; e_bd = 0; e_ma = 0;
        cyc = 0; ack_at = -100; deny = 0; waiting = 0;
    endtask

    task automatic model_step();
        int now, fut;
        bit pend, gnt;
        now = cyc & 3;
        fut = (cyc + 2) & 3;
        e_vv = s_vv[now]; e_vd = s_vd[now]; e_ack = s_ack[now];
        if (e_vv && !e_vd) e_pix = s_pix[now];
        if (e_ack) e_bd = s_bd[now];
        s_vv[now] = 0; s_vd[now] = 0; s_ack[now] = 0;
        pend = bus.bot_req && (waiting || cyc >= ack_at + 2);
        if (!bus.bot_req) begin
            waiting = 0;
            deny = 0;
        end
        gnt = pend && (!bus.vid_req || (SEN && deny >= LIM));
        if (gnt) begin
            s_ack[fut] = 1; s_bd[fut] = mem[bus.bot_addr];
            s_vv[fut] = bus.vid_req; s_vd[fut] = bus.vid_req;
            e_ma = bus.bot_addr; ack_at = cyc + 2; waiting = 0; deny = 0;
        end else if (bus.vid_req) begin
            s_vv[fut] = 1; s_pix[fut] = mem[bus.vid_addr]; e_ma = bus.vid_addr;
            if (pend) begin
                waiting = 1;
                deny++;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic vv, input logic vd, input logic [DW-1:0] pix,
                           input logic ack, input logic [DW-1:0] bd, input logic [AW-1:0] ma);
        chk({nm, " vid_valid"}, 32'(bus.vid_valid), 32'(vv));
        chk({nm, " vid_dropped"}, 32'(bus.vid_dropped), 32'(vd));
        chk({nm, " world_pixel"}, 32'(bus.world_pixel), 32'(pix));
        chk({nm, " bot_ack"}, 32'(bus.bot_ack), 32'(ack));
        chk({nm, " bot_data"}, 32'(bus.bot_data), 32'(bd));
        chk({nm, " map_addr"}, 32'(bus.map_addr), 32'(ma));
    endtask

    task automatic drive(input logic vr, input logic [AW-1:0] va, input logic br, input logic [AW-1:0] ba);
        bus.vid_req = vr; bus.vid_addr = va; bus.bot_req = br; bus.bot_addr = ba;
    endtask

    function automatic vec_t row(int vr, int va, int br, int ba, int vv, int vd, int pix, int ack, int bd, int ma);
        vec_t r;
        r.vr = 1'(vr); r.va = AW'(va); r.br = 1'(br); r.ba = AW'(ba);
        r.vv = 1'(vv); r.vd = 1'(vd); r.pix = DW'(pix); r.ack = 1'(ack); r.bd = DW'(bd); r.ma = AW'(ma);
        return r;
    endfunction

    initial begin
        int rob_k, ack_k, bot_last, j;
        logic [DW-1:0] cur_pix, cur_bd;
        logic breq;
        foreach (mem[a]) mem[a] = DW'($urandom);
        mem['h0081] = 2; mem['h3FFF] = 3; mem['h0010] = 1; mem['h0020] = 2;
        mem['h0030] = 3; mem['h0031] = 0; mem['h0040] = 1; mem['h0200] = 3;
        for (int k = 0; k < 22; k++) mem[AW'('h100 + k)] = DW'(k + 1);
        //            vr va      br ba       vv vd px ack bd ma
        tbl[0]  = row(1, 'h0081, 0, 0,       0, 0, 0, 0, 0, 'h0081);
        tbl[1]  = row(0, 0,      0, 0,       0, 0, 0, 0, 0, 'h0081);
        tbl[2]  = row(0, 0,      0, 0,       1, 0, 2, 0, 0, 'h0081);
        tbl[3]  = row(0, 0,      0, 0,       0, 0, 2, 0, 0, 'h0081);
        tbl[4]  = row(0, 0,      1, 'h3FFF,  0, 0, 2, 0, 0, 'h3FFF);
        tbl[5]  = row(0, 0,      1, 'h3FFF,  0, 0, 2, 0, 0, 'h3FFF);
        tbl[6]  = row(0, 0,      1, 'h3FFF,  0, 0, 2, 1, 3, 'h3FFF);
        tbl[7]  = row(0, 0,      1, 'h3FFF,  0, 0, 2, 0, 3, 'h3FFF);
        tbl[8]  = row(0, 0,      0, 0,       0, 0, 2, 0, 3, 'h3FFF);
        tbl[9]  = row(0, 0,      0, 0,       0, 0, 2, 0, 3, 'h3FFF);
        tbl[10] = row(0, 0,      0, 0,       0, 0, 2, 0, 3, 'h3FFF);
        tbl[11] = row(1, 'h0010, 1, 'h0020,  0, 0, 2, 0, 3, 'h0010);
        tbl[12] = row(0, 0,      1, 'h0020,  0, 0, 2, 0, 3, 'h0020);
        tbl[13] = row(0, 0,      1, 'h0020,  1, 0, 1, 0, 3, 'h0020);
        tbl[14] = row(0, 0,      1, 'h0020,  0, 0, 1, 1, 2, 'h0020);
        tbl[15] = row(0, 0,      1, 'h0020,  0, 0, 1, 0, 2, 'h0020);
        tbl[16] = row(0, 0,      0, 0,       0, 0, 1, 0, 2, 'h0020);
        tbl[17] = row(1, 'h0030, 1, 'h0040,  0, 0, 1, 0, 2, 'h0030);
        tbl[18] = row(1, 'h0031, 0, 0,       0, 0, 1, 0, 2, 'h0031);
        tbl[19] = row(0, 0,      0, 0,       1, 0, 3, 0, 2, 'h0031);
        tbl[20] = row(0, 0,      0, 0,       1, 0, 0, 0, 2, 'h0031);
        tbl[21] = row(0, 0,      0, 0,       0, 0, 0, 0, 2, 'h0031);

        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].vr, tbl[i].va, tbl[i].br, tbl[i].ba);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i].vv, tbl[i].vd, tbl[i].pix, tbl[i].ack, tbl[i].bd, tbl[i].ma);
        end

        // Contention right after a withdrawal: the starve count must start from zero.
        rob_k = SEN ? LIM : 22;
        ack_k = rob_k + 2;
        bot_last = ack_k + 1;
        cur_pix = 0;
        cur_bd = 2;
        for (int k = 0; k < 28; k++) begin
            drive(k <= 21, AW'('h100 + k), k <= bot_last, AW'('h200));
            @(negedge clk);
            j = k - 2;
            if (j >= 0 && j <= 21 && !(SEN && j == rob_k)) cur_pix = mem[AW'('h100 + j)];
            if (k == ack_k) cur_bd = mem['h200];
            chk($sformatf("cont%0d vid_valid", k), 32'(bus.vid_valid), 32'(j >= 0 && j <= 21));
            chk($sformatf("cont%0d vid_dropped", k), 32'(bus.vid_dropped), 32'(SEN && j == rob_k));
            chk($sformatf("cont%0d world_pixel", k), 32'(bus.world_pixel), 32'(cur_pix));
            chk($sformatf("cont%0d bot_ack", k), 32'(bus.bot_ack), 32'(k == ack_k));
            chk($sformatf("cont%0d bot_data", k), 32'(bus.bot_data), 32'(cur_bd));
            if (k <= 21)
                chk($sformatf("cont%0d map_addr", k), 32'(bus.map_addr), k == rob_k ? 32'h200 : 32'('h100 + k));
        end

        drive(0, 0, 1, 'h3FFF);
        @(negedge clk);
        drive(1, 'h0081, 1, 'h3FFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all("midreset", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("postreset%0d vid_valid", k), 32'(bus.vid_valid), 32'd0);
            chk($sformatf("postreset%0d bot_ack", k), 32'(bus.bot_ack), 32'd0);
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        breq = 0;
        bus.bot_addr = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!breq) begin
                if ($urandom_range(3) == 0) begin
                    breq = 1;
                    bus.bot_addr = AW'($urandom);
                end
            end else if (e_ack) begin
                if ($urandom_range(3) != 0) breq = 0;
            end else if (waiting && $urandom_range(15) == 0) begin
                breq = 0;
            end
            bus.bot_req = breq;
            bus.vid_req = (i % 64 < 24) ? 1'b1 : 1'($urandom_range(1));
            bus.vid_addr = AW'($urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk_all($sformatf("rnd%0d", i), e_vv, e_vd, e_pix, e_ack, e_bd, e_ma);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
